// File: rtl/dct_block_transpose_pkg.sv
// Shared defaults and types for the DCT row/column transpose buffer.
package dct_block_transpose_pkg;

  localparam int DCT_N = 8;
  localparam int DCT_W = 16;

  // One row (or column) of the default-size block.
  typedef logic [DCT_N-1:0][DCT_W-1:0] dct_row_t;

  // Block framing sideband carried with each beat.
  typedef struct packed {
    logic eob;
    logic sob;
    logic sof;
  } dct_sb_t;

endpackage

// File: rtl/dct_block_transpose_if.sv
// Row/column beat stream: valid/ready handshake, N words plus block sideband.
interface dct_block_transpose_if #(
  parameter int N = dct_block_transpose_pkg::DCT_N,
  parameter int W = dct_block_transpose_pkg::DCT_W
);
  logic                  valid;
  logic                  ready;
  logic [N-1:0][W-1:0]   data;
  logic                  sob;
  logic                  eob;
  logic                  sof;

  modport master (output valid, data, sob, eob, sof, input ready);
  modport slave  (input valid, data, sob, eob, sof, output ready);
endinterface

// File: rtl/dct_block_transpose_tr_bank.sv
// One N x N word bank: row-wide write port, read mux that returns either
// a column (transpose) or a row (bypass) selected by rd_idx.
module dct_block_transpose_tr_bank #(
  parameter int N = 8,
  parameter int W = 16,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       wr_row,
  input  logic [N-1:0][W-1:0] wr_data,
  input  logic [AW-1:0]       rd_idx,
  input  logic                rd_bypass,
  output logic [N-1:0][W-1:0] rd_data
);

  // mem[row][col]; contents are don't-care until written, so no reset
  logic [N-1:0][N-1:0][W-1:0] mem;

  // Row write
  always_ff @(posedge clk) begin
    if (we) mem[wr_row] <= wr_data;
  end

  // Per-lane read: lane i takes word i of row rd_idx (bypass) or row i's word rd_idx
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign rd_data[i] = rd_bypass ? mem[rd_idx][i] : mem[i][rd_idx];
  end

endmodule

// File: rtl/dct_block_transpose.sv
// Ping-pong N x N transpose buffer between the DCT row and column passes.
// Rows fill bank wb while columns drain bank rb; a bank changes hands by
// its full flag, so fill and drain of opposite banks overlap with no bubble.
module dct_block_transpose
  import dct_block_transpose_pkg::*;
#(
  parameter int N = DCT_N,
  parameter int W = DCT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dct_block_transpose_if.slave  in_if,
  dct_block_transpose_if.master out_if,
  input  logic                  cfg_bypass,
  output logic                  err_framing
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic          wb, rb;
  logic [1:0]    full, sof_q, byp_q;
  logic [AW-1:0] wr, rc;
  logic          err_q;

  logic          in_rdy, acc, fire, done_w, done_r, bad, vld;
  logic [AW-1:0] row;
  logic [1:0]    full_set, full_clr;
  dct_sb_t       sb;
  logic [N-1:0][W-1:0] rd_data [2];

  // Write-side decode: a stray sob restarts the block at row 0
  always_comb begin
    in_rdy   = !full[wb];
    acc      = in_if.valid && in_rdy;
    row      = in_if.sob ? '0 : wr;
    done_w   = acc && (row == LAST);
    bad      = (in_if.sob && (wr != '0)) ||
               (!in_if.sob && (wr == '0)) ||
               (in_if.eob != (row == LAST));
    fire     = full[rb] && out_if.ready;
    done_r   = fire && (rc == LAST);
    full_set = done_w ? (2'b01 << wb) : 2'b00;
    full_clr = done_r ? (2'b01 << rb) : 2'b00;
  end

  // Pointers, counters, bank flags and registered framing error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb    <= 1'b0;
      rb    <= 1'b0;
      wr    <= '0;
      rc    <= '0;
      full  <= '0;
      sof_q <= '0;
      byp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (acc) begin
        wr <= done_w ? '0 : row + 1'b1;
        if (row == '0) begin
          sof_q[wb] <= in_if.sof && in_if.sob;
          byp_q[wb] <= cfg_bypass;
        end
        if (done_w) wb <= ~wb;
      end
      if (fire) begin
        rc <= done_r ? '0 : rc + 1'b1;
        if (done_r) rb <= ~rb;
      end
      // set and clear never hit the same bank: fill needs it empty, drain needs it full
      full  <= (full | full_set) & ~full_clr;
      err_q <= acc && bad;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_block_transpose_tr_bank #(.N(N), .W(W)) u_bank (
      .clk       (clk),
      .we        (acc && (wb == 1'(b))),
      .wr_row    (row),
      .wr_data   (in_if.data),
      .rd_idx    (rc),
      .rd_bypass (byp_q[b]),
      .rd_data   (rd_data[b])
    );
  end

  // Output beat: data and sideband forced to zero when no bank is ready
  always_comb begin
    vld            = full[rb];
    sb.sob         = vld && (rc == '0);
    sb.eob         = vld && (rc == LAST);
    sb.sof         = vld && sof_q[rb] && (rc == '0);
    out_if.valid   = vld;
    out_if.data    = vld ? rd_data[rb] : '0;
    out_if.sob     = sb.sob;
    out_if.eob     = sb.eob;
    out_if.sof     = sb.sof;
  end

  assign in_if.ready = in_rdy;
  assign err_framing = err_q;

endmodule
